// File: rtl/traffic_monitor.sv
// Independent lamp checker for the intersection controller: decodes lamps into a
// phase, times each phase in ticks, and latches the first rule violation.
module traffic_monitor #(
   parameter int GREEN_MIN  = 10,
   parameter int GREEN_MAX  = 31,
   parameter int YELLOW_MIN = 3,
   parameter int YELLOW_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ns_green,
   input  logic       ns_yellow,
   input  logic       ns_red,
   input  logic       ew_green,
   input  logic       ew_yellow,
   input  logic       ew_red,
   input  logic       fault_clr,
   output logic [2:0] phase,
   output logic       phase_done,
   output logic [5:0] phase_len,
   output logic [7:0] cycle_count,
   output logic       fault,
   output logic [2:0] fault_code
);

   typedef enum logic [2:0] {UNKNOWN = 3'd0, NS_G = 3'd1, NS_Y = 3'd2, EW_G = 3'd3, EW_Y = 3'd4} phase_t;
   typedef enum logic [2:0] {F_NONE = 3'd0, F_ILLEGAL = 3'd1, F_CONFLICT = 3'd2,
                             F_SEQ = 3'd3, F_SHORT = 3'd4, F_LONG = 3'd5} fcode_t;

   phase_t     cur, obs;
   fcode_t     det;
   logic [5:0] dur;
   logic       first;
   logic       conflict;
   logic [5:0] min_v, max_v;

   function automatic phase_t succ(input phase_t p);
      case (p)
         NS_G:    succ = NS_Y;
         NS_Y:    succ = EW_G;
         EW_G:    succ = EW_Y;
         EW_Y:    succ = NS_G;
         default: succ = UNKNOWN;
      endcase
   endfunction

   // Lamp decode; UNKNOWN here means the observation is not a legal phase.
   always_comb begin
      conflict = !ns_red && !ew_red;
      case ({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red})
         6'b100_001: obs = NS_G;
         6'b010_001: obs = NS_Y;
         6'b001_100: obs = EW_G;
         6'b001_010: obs = EW_Y;
         default:    obs = UNKNOWN;
      endcase
   end

   always_comb begin
      if (cur == NS_G || cur == EW_G) begin
         min_v = 6'(GREEN_MIN);
         max_v = 6'(GREEN_MAX);
      end else begin
         min_v = 6'(YELLOW_MIN);
         max_v = 6'(YELLOW_MAX);
      end
   end

   // Fault detected this cycle; branch order encodes the same-cycle priority.
   always_comb begin
      det = F_NONE;
      if (conflict)
         det = F_CONFLICT;
      else if (obs == UNKNOWN)
         det = F_ILLEGAL;
      else if (obs == cur) begin
         if (tick && !first && dur == max_v)
            det = F_LONG;
      end else if (cur != UNKNOWN && obs != succ(cur))
         det = F_SEQ;
      else if (!first && dur < min_v)
         det = F_SHORT;
   end

   assign phase = cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur         <= UNKNOWN;
         dur         <= 6'd0;
         first       <= 1'b1;
         phase_done  <= 1'b0;
         phase_len   <= 6'd0;
         cycle_count <= 8'd0;
         fault       <= 1'b0;
         fault_code  <= 3'd0;
      end else begin
         phase_done <= 1'b0;
         if (conflict || obs == UNKNOWN) begin
            cur   <= UNKNOWN;
            dur   <= 6'd0;
            first <= 1'b1;
         end else if (obs == cur) begin
            if (tick && dur != 6'd63)
               dur <= dur + 6'd1;
         end else begin
            if (cur != UNKNOWN) begin
               phase_done <= 1'b1;
               phase_len  <= dur;
            end
            if (cur == EW_Y && obs == NS_G)
               cycle_count <= cycle_count + 8'd1;
            // A phase entered from UNKNOWN or out of order has no trustworthy start time.
            first <= (cur == UNKNOWN) || (det == F_SEQ);
            cur   <= obs;
            dur   <= {5'd0, tick};
         end

         if (fault_clr) begin
            fault      <= (det != F_NONE);
            fault_code <= det;
         end else if (!fault && det != F_NONE) begin
            fault      <= 1'b1;
            fault_code <= det;
         end
      end
   end

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed test-plan scenarios plus a randomized lamp walk, each cycle compared
// against a behavioural model of the monitor's rules.
module tb_traffic_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       fault_clr = 1'b0;
   logic [5:0] lam = 6'b0;
   logic [2:0] phase;
   logic       phase_done;
   logic [5:0] phase_len;
   logic [7:0] cycle_count;
   logic       fault;
   logic [2:0] fault_code;

   int n_chk = 0;
   int n_pass = 0;
   int pd_q[$];

   // model state
   int m_cur, m_dur, m_first, m_pd, m_len, m_cyc, m_fault, m_code;

   traffic_monitor #(.GREEN_MIN(10), .GREEN_MAX(31), .YELLOW_MIN(3), .YELLOW_MAX(4)) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .ns_green(lam[5]), .ns_yellow(lam[4]), .ns_red(lam[3]),
      .ew_green(lam[2]), .ew_yellow(lam[1]), .ew_red(lam[0]),
      .fault_clr(fault_clr), .phase(phase), .phase_done(phase_done), .phase_len(phase_len),
      .cycle_count(cycle_count), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] CONFLICT_LAMPS = 6'b100_100;

   function automatic logic [5:0] lamps(input int p);
      case (p)
         1:       return 6'b100_001;
         2:       return 6'b010_001;
         3:       return 6'b001_100;
         default: return 6'b001_010;
      endcase
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      m_cur = 0; m_dur = 0; m_first = 1; m_pd = 0; m_len = 0;
      m_cyc = 0; m_fault = 0; m_code = 0;
   endtask

   task automatic model(input logic [5:0] l, input logic tk, input logic clr);
      int obs, det, lo, hi;
      bit seq;
      det = 0;
      m_pd = 0;
      obs = 0;
      for (int p = 1; p <= 4; p++) if (l == lamps(p)) obs = p;
      lo = (m_cur == 1 || m_cur == 3) ? 10 : 3;
      hi = (m_cur == 1 || m_cur == 3) ? 31 : 4;
      if (!l[3] && !l[0]) det = 2;
      else if (obs == 0) det = 1;
      if (det != 0) begin
         m_cur = 0; m_dur = 0; m_first = 1;
      end else if (obs == m_cur) begin
         if (tk) begin
            if (!m_first && m_dur + 1 == hi + 1) det = 5;
            m_dur = (m_dur + 1 > 63) ? 63 : m_dur + 1;
         end
      end else begin
         seq = (m_cur != 0) && (obs != (m_cur % 4) + 1);
         if (seq) det = 3;
         else if (m_cur != 0 && !m_first && m_dur < lo) det = 4;
         if (m_cur != 0) begin m_pd = 1; m_len = m_dur; end
         if (m_cur == 4 && obs == 1) m_cyc = (m_cyc + 1) % 256;
         m_first = (m_cur == 0 || seq) ? 1 : 0;
         m_cur = obs;
         m_dur = tk ? 1 : 0;
      end
      if (clr) begin
         m_fault = (det != 0); m_code = det;
      end else if (!m_fault && det != 0) begin
         m_fault = 1; m_code = det;
      end
   endtask

   task automatic step(input logic [5:0] l, input logic tk, input logic clr);
      lam = l; tick = tk; fault_clr = clr;
      @(posedge clk);
      model(l, tk, clr);
      #1;
      chk("phase", phase, m_cur);
      chk("phase_done", phase_done, m_pd);
      chk("phase_len", phase_len, m_len);
      chk("cycle_count", cycle_count, m_cyc);
      chk("fault", fault, m_fault);
      chk("fault_code", fault_code, m_code);
      if (phase_done) pd_q.push_back(int'(phase_len));
   endtask

   task automatic drive(input int p, input int n);
      repeat (n) step(lamps(p), 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("rst_phase", phase, 0);
      chk("rst_phase_done", phase_done, 0);
      chk("rst_phase_len", phase_len, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_code", fault_code, 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int p, len, r;
      model_reset();
      do_reset();

      // nominal run
      pd_q.delete();
      drive(1, 10); drive(2, 3); drive(3, 10); drive(4, 3); drive(1, 10);
      chk("nom_cycle_count", cycle_count, 1);
      drive(2, 3);
      chk("nom_pd_count", pd_q.size(), 5);
      if (pd_q.size() == 5) begin
         chk("nom_len0", pd_q[0], 10); chk("nom_len1", pd_q[1], 3);
         chk("nom_len2", pd_q[2], 10); chk("nom_len3", pd_q[3], 3);
         chk("nom_len4", pd_q[4], 10);
      end
      chk("nom_fault", fault, 0);

      // sequence fault: checked NS_G of 12 ticks jumps straight to EW_G
      drive(3, 10); drive(4, 3); drive(1, 12);
      step(lamps(3), 1'b1, 1'b0);
      chk("seq_code", fault_code, 3);
      chk("seq_pd", phase_done, 1);
      chk("seq_len", phase_len, 12);

      // short yellow
      step(lamps(3), 1'b1, 1'b1);
      chk("clr1_fault", fault, 0);
      drive(3, 8); drive(4, 3); drive(1, 10); drive(2, 2);
      step(lamps(3), 1'b1, 1'b0);
      chk("short_code", fault_code, 4);
      chk("short_len", phase_len, 2);
      drive(3, 9); drive(4, 1);
      step(lamps(1), 1'b1, 1'b0);
      chk("short_hold_code", fault_code, 4);

      // long green
      step(lamps(1), 1'b1, 1'b1);
      chk("clr2_fault", fault, 0);
      drive(1, 8); drive(2, 3); drive(3, 10); drive(4, 3); drive(1, 31);
      chk("long_pre_fault", fault, 0);
      step(lamps(1), 1'b1, 1'b0);
      chk("long_code", fault_code, 5);
      chk("long_phase", phase, 1);
      step(lamps(1), 1'b1, 1'b1);
      chk("clr3_fault", fault, 0);
      step(CONFLICT_LAMPS, 1'b1, 1'b1);
      chk("conf_fault", fault, 1);
      chk("conf_code", fault_code, 2);
      chk("conf_phase", phase, 0);
      step(lamps(1), 1'b1, 1'b1);
      chk("resync_fault", fault, 0);
      chk("resync_phase", phase, 1);

      // reset mid EW_G, then an unchecked short EW_G and a clean EW_Y
      drive(1, 9); drive(2, 3); drive(3, 5);
      do_reset();
      drive(3, 3); drive(4, 3);
      step(lamps(1), 1'b1, 1'b0);
      chk("post_rst_fault", fault, 0);

      // randomized walk
      p = 1;
      repeat (400) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            do_reset();
         end else if (r < 8) begin
            repeat ($urandom_range(1, 3))
               step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
         end else begin
            p = (r < 14) ? $urandom_range(1, 4) : (p % 4) + 1;
            len = (p == 1 || p == 3) ? $urandom_range(8, 40) : $urandom_range(1, 6);
            repeat (len)
               step(lamps(p), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
